// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: RV32I funct3 codes,
// the FSM state type and the access-legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Misalignment or an undefined funct3 for the given direction.
    function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic illegal;
        case (f3)
            F3_B:    illegal = 1'b0;
            F3_BU:   illegal = we;
            F3_H:    illegal = off[0];
            F3_HU:   illegal = off[0] | we;
            F3_W:    illegal = (off != 2'b00);
            default: illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core-request/response and word-memory port bundle of the load/store master.
interface lsu_mem_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension from the read word and
// store lane merge into the previously read word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_word[8*offset +: 8];
    assign half_sel = rd_word[16*offset[1] +: 16];

    always_comb begin
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Each byte lane takes store data when it is covered by the access width.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_src;

            assign lane_hit = (funct3 == F3_W)
                            || ((funct3 == F3_B) && (offset == LANE))
                            || ((funct3 == F3_H) && (offset[1] == LANE[1]));
            assign lane_src = (funct3 == F3_W) ? wdata[8*gi +: 8]
                            : (funct3 == F3_H) ? wdata[8*(gi%2) +: 8]
                            : wdata[7:0];
            assign merged[8*gi +: 8] = lane_hit ? lane_src : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-only memory; sub-word stores use
// read-modify-write. Optional address range check: LSU_RANGE_CHECK_EN.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h00002000,
    parameter int                    DEPTH_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_master_if.master   bus
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH:0] LIMIT =
        {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * DEPTH_WORDS);

    lsu_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [2:0]            f3_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] old_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  err_reg;

    logic                  accept;
    logic                  in_range;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    assign accept   = bus.req_valid && (state_reg == IDLE);
    assign in_range = (bus.req_addr >= BASE_ADDR) && ({1'b0, bus.req_addr} < LIMIT);
    assign req_err  = access_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
                    || (RANGE_EN && !in_range);

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3    (f3_reg),
        .offset    (addr_reg[1:0]),
        .rd_word   (bus.mem_rd),
        .old_word  (old_reg),
        .wdata     (wdata_reg),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            f3_reg    <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            old_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= bus.req_addr;
                f3_reg    <= bus.req_funct3;
                we_reg    <= bus.req_we;
                wdata_reg <= bus.req_wdata;
                rdata_reg <= '0;
                err_reg   <= req_err;
            end
            // The read cycle either captures the old word (RMW) or the load result.
            if (state_reg == READ) begin
                if (we_reg) old_reg   <= bus.mem_rd;
                else        rdata_reg <= load_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                                  state_next = RESP;
                    else if (bus.req_we && bus.req_funct3 == F3_W) state_next = WRITE;
                    else                                          state_next = READ;
                end
            end
            READ:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_reg == IDLE);
        bus.resp_valid = (state_reg == RESP);
        bus.resp_err   = (state_reg == RESP) && err_reg;
        bus.resp_rdata = (state_reg == RESP) ? rdata_reg : '0;
        bus.mem_we     = 1'b0;
        bus.mem_a      = '0;
        bus.mem_wd     = '0;
        if (state_reg == READ || state_reg == WRITE)
            bus.mem_a = {addr_reg[DATA_WIDTH-1:2], 2'b00};
        if (state_reg == WRITE) begin
            bus.mem_we = !rst;
            bus.mem_wd = merged;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a word-only memory model.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.DATA_WIDTH(32)) bus ();

    lsu_mem_master #(
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h00002000),
        .DEPTH_WORDS(1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] mem [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    assign bus.mem_rd = mem[bus.mem_a[11:2]];

    always @(posedge clk) begin
        if (bd_we)           mem[bd_idx] <= bd_data;
        else if (bus.mem_we) mem[bus.mem_a[11:2]] <= bus.mem_wd;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_wes);
        int lat, wes;
        logic [31:0] rd;
        logic er;
        lat = 0; wes = 0; rd = 'x; er = 1'bx;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_we) wes++;
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, rd, exp_rdata);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
        chk({tag, ".we_pulses"}, 32'(wes), 32'(exp_wes));
        $display("txn %s we=%0b f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d wes=%0d",
                 tag, we, f3, addr, wdata, rd, er, lat, wes);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready",  32'(bus.req_ready), 32'd1);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.resp_err",   32'(bus.resp_err), 32'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst.mem_we",     32'(bus.mem_we), 32'd0);
        chk("rst.mem_a",      bus.mem_a, 32'd0);
        chk("rst.mem_wd",     bus.mem_wd, 32'd0);

        preload(10'd0, 32'hCAFEF00D);
        preload(10'd1, 32'h8899AABB);
        preload(10'd2, 32'h11223344);
        preload(10'd3, 32'h00000000);
        @(negedge clk) rst = 1'b0;

        // Loads
        txn("LB_2005",  1'b0, F3_B,  32'h2005, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        txn("LBU_2005", 1'b0, F3_BU, 32'h2005, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        txn("LB_2004",  1'b0, F3_B,  32'h2004, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
        txn("LHU_2006", 1'b0, F3_HU, 32'h2006, 32'h0, 32'h00008899, 1'b0, 2, 0);
        txn("LH_2006",  1'b0, F3_H,  32'h2006, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        txn("LH_2004",  1'b0, F3_H,  32'h2004, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);

        // Sub-word stores via read-modify-write
        txn("SB_200A", 1'b1, F3_B, 32'h200A, 32'hFFFFFF55, 32'h0, 1'b0, 3, 1);
        chk("mem.2008_after_SB", mem[2], 32'h11553344);
        txn("SH_2004", 1'b1, F3_H, 32'h2004, 32'h1234CDEF, 32'h0, 1'b0, 3, 1);
        chk("mem.2004_after_SH", mem[1], 32'h8899CDEF);

        // Word store then read back
        txn("SW_200C", 1'b1, F3_W, 32'h200C, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("mem.200C_after_SW", mem[3], 32'hDEADBEEF);
        txn("LW_200C", 1'b0, F3_W, 32'h200C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        // Error path
        txn("LW_2002_mis",  1'b0, F3_W,  32'h2002, 32'h0, 32'h0, 1'b1, 1, 0);
        txn("SH_2001_mis",  1'b1, F3_H,  32'h2001, 32'h0000AAAA, 32'h0, 1'b1, 1, 0);
        chk("mem.2000_unchanged", mem[0], 32'hCAFEF00D);
        txn("LD_f3_3",      1'b0, 3'd3,  32'h2000, 32'h0, 32'h0, 1'b1, 1, 0);
        txn("ST_f3_4",      1'b1, F3_BU, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 0);
        chk("mem.2000_unchanged2", mem[0], 32'hCAFEF00D);

`ifdef LSU_RANGE_CHECK_EN
        txn("LW_1FFC_range", 1'b0, F3_W, 32'h1FFC, 32'h0, 32'h0, 1'b1, 1, 0);
        txn("LW_3008_range", 1'b0, F3_W, 32'h3008, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        txn("LW_3008_alias", 1'b0, F3_W, 32'h3008, 32'h0, 32'h11553344, 1'b0, 2, 0);
`endif

        // Reset asserted during the WRITE cycle of an SB
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
        bus.req_addr = 32'h2008; bus.req_wdata = 32'h00000077;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("rstw.read_mem_a", bus.mem_a, 32'h2008);
        @(posedge clk);
        #1;
        chk("rstw.write_mem_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw.gated_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstw.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstw.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstw.mem_unchanged", mem[2], 32'h11553344);
        @(posedge clk);
        #1;
        chk("rstw.no_resp_after", 32'(bus.resp_valid), 32'd0);
        chk("rstw.idle_mem_a", bus.mem_a, 32'd0);
        $display("txn SB_rst_in_write addr=00002008 -> mem=%h", mem[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
